addsub_op_queue: RTL and testbench

//  Upstream issue stage for add_sub_4bit: buffers {ctrl,a,b} operations in a DEPTH-entry FIFO.

---
 rtl/addsub_op_queue.sv | 127 ++++++++++++
 tb/tb_addsub_op_queue.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_op_queue.sv
// Issue queue in front of a combinational add/sub unit: buffers {ctrl,a,b} ops in a FIFO,
// presents the head to the unit and registers its result. Optional status ports: ADDSUB_Q_STATUS_EN.
module addsub_op_queue #(
  parameter int DATA_SIZE = 4,
  parameter int DEPTH     = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   op_valid_in,
  output logic                   op_ready_out,
  input  logic [DATA_SIZE-1:0]   op_a_in,
  input  logic [DATA_SIZE-1:0]   op_b_in,
  input  logic                   op_ctrl_in,
  output logic [DATA_SIZE-1:0]   a_out,
  output logic [DATA_SIZE-1:0]   b_out,
  output logic                   control_out,
  input  logic [DATA_SIZE-1:0]   result_in,
  input  logic                   carry_in,
  output logic                   res_valid_out,
  input  logic                   res_ready_in,
  output logic [DATA_SIZE-1:0]   res_data_out,
  output logic                   res_carry_out
`ifdef ADDSUB_Q_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] level_out,
  output logic [7:0]             done_cnt_out
`endif
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int ENTRY_W = 2 * DATA_SIZE + 1;
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic                 run_q;
  logic                 res_valid_q, res_valid_d;
  logic [DATA_SIZE-1:0] res_data_q, res_data_d;
  logic                 res_carry_q, res_carry_d;
  logic                 push, pop, deliver, not_empty;
  logic [ENTRY_W-1:0]   head_entry;

  assign not_empty    = (count_q != '0);
  assign op_ready_out = run_q & (count_q != FULL_CNT);
  assign push         = op_valid_in & op_ready_out;
  assign pop          = not_empty & (~res_valid_q | res_ready_in);
  assign deliver      = res_valid_q & res_ready_in;

  // An empty queue presents all-zero operands so the attached unit sees a quiet input.
  assign head_entry = not_empty ? mem_q[rd_ptr_q] : '0;
  assign {control_out, a_out, b_out} = head_entry;

  assign res_valid_out = res_valid_q;
  assign res_data_out  = res_data_q;
  assign res_carry_out = res_carry_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;

    // A pop refills the result register, which also covers a same-cycle delivery.
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      res_valid_d = 1'b1;
      res_data_d  = result_in;
      res_carry_d = carry_in;
    end else if (deliver) begin
      res_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops are written with non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      run_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      run_q       <= 1'b1;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
    end
  end

  // NOTE: the storage array is not reset; an entry is only read after it has been written, guarded by count.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= {op_ctrl_in, op_a_in, op_b_in};
  end

`ifdef ADDSUB_Q_STATUS_EN
  logic [7:0] done_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)    done_cnt_q <= 8'd0;
    else if (deliver) done_cnt_q <= done_cnt_q + 8'd1;
  end

  assign level_out    = count_q;
  assign done_cnt_out = done_cnt_q;
`endif

endmodule

// File: tb/tb_addsub_op_queue.sv
// Self-checking bench for addsub_op_queue: queue-level model, per-cycle compare, in-order scoreboard
// and directed vectors. Status-port checks are compiled in when ADDSUB_Q_STATUS_EN is defined.
`timescale 1ns/1ps
module tb_addsub_op_queue;

  localparam int DS    = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct packed {
    logic [DS-1:0] a;
    logic [DS-1:0] b;
    logic          ctrl;
  } op_t;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          op_valid_in, op_ready_out, op_ctrl_in;
  logic [DS-1:0] op_a_in, op_b_in;
  logic [DS-1:0] a_out, b_out, result_in, res_data_out;
  logic          control_out, carry_in, res_valid_out, res_ready_in, res_carry_out;
`ifdef ADDSUB_Q_STATUS_EN
  logic [AW:0]   level_out;
  logic [7:0]    done_cnt_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  addsub_op_queue #(.DATA_SIZE(DS), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .op_valid_in(op_valid_in), .op_ready_out(op_ready_out),
    .op_a_in(op_a_in), .op_b_in(op_b_in), .op_ctrl_in(op_ctrl_in),
    .a_out(a_out), .b_out(b_out), .control_out(control_out),
    .result_in(result_in), .carry_in(carry_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .res_data_out(res_data_out), .res_carry_out(res_carry_out)
`ifdef ADDSUB_Q_STATUS_EN
    , .level_out(level_out), .done_cnt_out(done_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Stand-in for the attached add_sub_4bit: carry on add, borrow on subtract.
  always_comb begin
    result_in = '0;
    carry_in  = 1'b0;
    if (control_out) begin
      result_in = a_out - b_out;
      carry_in  = (a_out < b_out);
    end else begin
      {carry_in, result_in} = {1'b0, a_out} + {1'b0, b_out};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {carry, result} from plain integer arithmetic.
  function automatic logic [DS:0] ref_res(input op_t op);
    int s;
    logic c;
    if (op.ctrl) begin
      s = int'(op.a) - int'(op.b);
      c = (s < 0);
      s = s + 16;
    end else begin
      s = int'(op.a) + int'(op.b);
      c = (s > 15);
    end
    return {c, DS'(s % 16)};
  endfunction

  // ---------------- queue-level model ----------------
  op_t           m_fifo[$];
  logic [DS:0]   sb[$];
  logic          m_rv   = 1'b0;
  logic [DS:0]   m_res  = '0;
  bit            m_run  = 1'b0;
  int            m_done = 0;

  initial forever begin
    bit do_push, do_pop, do_del;
    op_t op;
    @(posedge clk_in or negedge rst_n_in);
    if (!rst_n_in) begin
      m_fifo.delete();
      sb.delete();
      m_rv  = 1'b0;
      m_res = '0;
      m_run = 1'b0;
      m_done = 0;
    end else begin
      do_push = op_valid_in && m_run && (m_fifo.size() < DEPTH);
      do_pop  = (m_fifo.size() > 0) && (!m_rv || res_ready_in);
      do_del  = m_rv && res_ready_in;
      if (do_del) m_done = (m_done + 1) % 256;
      if (do_pop) begin
        m_res = ref_res(m_fifo.pop_front());
        m_rv  = 1'b1;
      end else if (do_del) begin
        m_rv = 1'b0;
      end
      if (do_push) begin
        op = '{a: op_a_in, b: op_b_in, ctrl: op_ctrl_in};
        m_fifo.push_back(op);
        sb.push_back(ref_res(op));
      end
      m_run = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic [2*DS:0] exp_head;
    @(negedge clk_in);
    check("ready", op_ready_out, m_run && (m_fifo.size() < DEPTH));
    check("res_valid", res_valid_out, m_rv);
    if (m_rv) check("res_value", {res_carry_out, res_data_out}, m_res);
    exp_head = (m_fifo.size() > 0) ? {m_fifo[0].ctrl, m_fifo[0].a, m_fifo[0].b} : '0;
    check("head", {control_out, a_out, b_out}, exp_head);
`ifdef ADDSUB_Q_STATUS_EN
    check("level", level_out, m_fifo.size());
    check("done_cnt", done_cnt_out, m_done);
`endif
    if (rst_n_in && res_valid_out && res_ready_in) begin
      if (sb.size() == 0) check("sb_extra_result", 1, 0);
      else check("sb_order", {res_carry_out, res_data_out}, sb.pop_front());
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [DS-1:0] a, input logic [DS-1:0] b, input logic c);
    op_valid_in = 1'b1;
    op_a_in     = a;
    op_b_in     = b;
    op_ctrl_in  = c;
  endtask

  op_t         t4_ops[6] = '{'{4'd1, 4'd1, 1'b0}, '{4'd2, 4'd3, 1'b0}, '{4'd15, 4'd1, 1'b0},
                             '{4'd4, 4'd6, 1'b1}, '{4'd8, 4'd8, 1'b1}, '{4'd5, 4'd5, 1'b0}};
  logic [DS:0] t4_exp[5] = '{5'h02, 5'h05, 5'h10, 5'h1E, 5'h00};

  initial begin
    int idx, first_v, n_v, last_v, pushes;
    bit acc;
    rst_n_in = 1'b0;
    op_valid_in = 1'b0; op_a_in = '0; op_b_in = '0; op_ctrl_in = 1'b0;
    res_ready_in = 1'b1;

    // Pin the reference arithmetic itself.
    check("ref_add_9_8", ref_res('{4'd9, 4'd8, 1'b0}), 5'h11);
    check("ref_sub_3_5", ref_res('{4'd3, 4'd5, 1'b1}), 5'h1E);
    check("ref_sub_7_2", ref_res('{4'd7, 4'd2, 1'b1}), 5'h05);

    repeat (2) @(posedge clk_in);
    check("rst_valid", res_valid_out, 0);
    check("rst_ready", op_ready_out, 0);
    #3 rst_n_in = 1'b1;
    tick();
    check("ready_after_release", op_ready_out, 1);

    // Add: 9+8 = 0x11
    drive(4'd9, 4'd8, 1'b0);
    tick();
    op_valid_in = 1'b0;
    check("add_not_yet", res_valid_out, 0);
    tick();
    check("add_valid", res_valid_out, 1);
    check("add_data", res_data_out, 4'h1);
    check("add_carry", res_carry_out, 1);

    // Subtract, back to back
    drive(4'd3, 4'd5, 1'b1);
    tick();
    drive(4'd7, 4'd2, 1'b1);
    tick();
    op_valid_in = 1'b0;
    check("sub1_data", res_data_out, 4'hE);
    check("sub1_borrow", res_carry_out, 1);
    tick();
    check("sub2_data", res_data_out, 4'h5);
    check("sub2_borrow", res_carry_out, 0);
    repeat (2) tick();

    // Backpressure: six offered, five fit (four queued + one held)
    res_ready_in = 1'b0;
    idx = 0;
    drive(t4_ops[0].a, t4_ops[0].b, t4_ops[0].ctrl);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk_in);
      acc = op_ready_out;
      tick();
      if (acc) begin
        idx++;
        if (idx < 6) drive(t4_ops[idx].a, t4_ops[idx].b, t4_ops[idx].ctrl);
      end
    end
    check("full_accepted", idx, 5);
    check("full_ready_low", op_ready_out, 0);
`ifdef ADDSUB_Q_STATUS_EN
    check("full_level", level_out, 4);
`endif
    op_valid_in  = 1'b0;
    res_ready_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      check("drain_valid", res_valid_out, 1);
      check("drain_value", {res_carry_out, res_data_out}, t4_exp[k]);
      @(posedge clk_in);
    end
    #1;
    check("ready_reasserted", op_ready_out, 1);
    @(negedge clk_in);
    check("drained_valid", res_valid_out, 0);

    // Throughput: 8 consecutive ops -> 8 consecutive results
    first_v = -1; n_v = 0; last_v = -1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk_in);
      #1;
      if (k < 8) drive(DS'(k + 3), DS'(2 * k), k[0]);
      else op_valid_in = 1'b0;
      @(negedge clk_in);
      if (res_valid_out) begin
        if (first_v < 0) first_v = k;
        n_v++;
        last_v = k;
      end
    end
    check("tput_first", first_v, 2);
    check("tput_count", n_v, 8);
    check("tput_last", last_v, 9);

    // Random source and sink gaps; scoreboard watches order
    acc = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (!op_valid_in || acc) begin
        if ($urandom_range(1, 0) == 1) drive(DS'($urandom), DS'($urandom), 1'($urandom));
        else op_valid_in = 1'b0;
      end
      res_ready_in = ($urandom_range(3, 0) != 0);
      @(negedge clk_in);
      acc = op_valid_in && op_ready_out;
    end
    tick();
    op_valid_in  = 1'b0;
    res_ready_in = 1'b1;
    for (int k = 0; k < 20 && (sb.size() != 0); k++) tick();
    check("random_drained", sb.size(), 0);

    // Reset mid-stream with three ops outstanding
    res_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(DS'(k + 1), DS'(1), 1'b0);
      tick();
    end
    op_valid_in = 1'b0;
    @(posedge clk_in);
    #3 rst_n_in = 1'b0;
    #1;
    check("midrst_valid", res_valid_out, 0);
    check("midrst_ready", op_ready_out, 0);
    repeat (2) @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    #1;
    check("release_ready_low", op_ready_out, 0);
    tick();
    check("release_ready_high", op_ready_out, 1);
    check("release_valid", res_valid_out, 0);
`ifdef ADDSUB_Q_STATUS_EN
    check("release_level", level_out, 0);
`endif
    res_ready_in = 1'b1;
    repeat (3) tick();
    check("no_stale", res_valid_out, 0);

`ifdef ADDSUB_Q_STATUS_EN
    // 257 deliveries wrap the done counter to 1
    pushes = 0;
    drive(4'd1, 4'd2, 1'b0);
    for (int k = 0; k < 400 && pushes < 257; k++) begin
      @(negedge clk_in);
      if (op_ready_out) pushes++;
      tick();
      if (pushes == 257) op_valid_in = 1'b0;
      else drive(DS'(pushes), DS'(k), 1'b0);
    end
    check("status_pushes", pushes, 257);
    repeat (5) tick();
    check("done_wrap", done_cnt_out, 1);

    // Simultaneous push and pop leaves the level unchanged
    res_ready_in = 1'b0;
    drive(4'd2, 4'd2, 1'b0);
    tick();
    drive(4'd3, 4'd3, 1'b0);
    tick();
    op_valid_in = 1'b0;
    tick();
    check("level_before", level_out, 1);
    drive(4'd4, 4'd4, 1'b0);
    res_ready_in = 1'b1;
    tick();
    op_valid_in = 1'b0;
    check("level_after", level_out, 1);
    check("level_valid", res_valid_out, 1);
    repeat (4) tick();
`else
    pushes = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
